// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: UART command controller with burst-read support.
//
// Parses byte frames from the synchronised UART RX path and turns them into
// register-file writes/reads, ALU operations and TX-FIFO pushes.
//   0xAA addr data      : register write
//   0xBB addr           : register read, result pushed to the TX FIFO
//   0xCC A B fun        : write A->reg0, B->reg1, run ALU, push result lo/hi
//   0xDD fun            : run ALU on current reg0/reg1, push result lo/hi
//   0xEE addr cnt       : burst read of cnt registers starting at addr
//
// Ports:
//   CLK, RST                 reference clock, async active-low reset
//   RX_p_data, RX_d_valid    incoming byte + one-cycle valid pulse
//   Rd_data, RdData_valid    register-file read response
//   ALU_OUT, OUT_VALID       ALU result (two bytes wide) + valid
//   FIFO_full                TX FIFO back-pressure
//   ALU_EN, ALU_FUN, CLK_EN  ALU start pulse, function code, clock-gate enable
//   Address, WrEN, RdEN,
//   WrData                   register-file access
//   TX_p_data, TX_d_valid    TX FIFO write port
//   clk_div_en               UART clock-divider enable (1 after reset)
//   cmd_error                one-cycle pulse on bad opcode, timeout, stray byte
//
// Every output comes straight from a flop; each strobe appears in the cycle
// after the input event that triggered it.
module sys_ctrl_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_p_data,
    input  logic                      RX_d_valid,
    input  logic [DATA_WIDTH-1:0]     Rd_data,
    input  logic                      RdData_valid,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      OUT_VALID,
    input  logic                      FIFO_full,
    output logic                      ALU_EN,
    output logic [3:0]                ALU_FUN,
    output logic                      CLK_EN,
    output logic [ADDR_WIDTH-1:0]     Address,
    output logic                      WrEN,
    output logic                      RdEN,
    output logic [DATA_WIDTH-1:0]     WrData,
    output logic [DATA_WIDTH-1:0]     TX_p_data,
    output logic                      TX_d_valid,
    output logic                      clk_div_en,
    output logic                      cmd_error
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [31:0] TMO_LIM = 32'(TIMEOUT);

    localparam logic [DATA_WIDTH-1:0] OP_WR    = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD    = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU   = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_N = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] OP_BURST = DATA_WIDTH'(8'hEE);

    typedef enum logic [4:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_PUSH,
        S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_START, S_ALU_WAIT,
        S_PUSH_LO, S_PUSH_HI, S_BR_ADDR, S_BR_CNT, S_BR_READ,
        S_BR_WAIT, S_BR_PUSH
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0]   alu_res_q, alu_res_d;
    logic [TW-1:0]             tmo_q, tmo_d;

    logic                      alu_en_q, alu_en_d;
    logic [3:0]                alu_fun_q, alu_fun_d;
    logic                      clk_en_q, clk_en_d;
    logic [ADDR_WIDTH-1:0]     address_q, address_d;
    logic                      wren_q, wren_d;
    logic                      rden_q, rden_d;
    logic [DATA_WIDTH-1:0]     wrdata_q, wrdata_d;
    logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      clk_div_en_q, clk_div_en_d;
    logic                      cmd_error_q, cmd_error_d;

    logic                      collecting;
    logic                      stray_rx;
    logic                      tmo_hit;
    logic [31:0]               tmo_next;
    logic [ADDR_WIDTH-1:0]     rx_addr;

    assign rx_addr = RX_p_data[ADDR_WIDTH-1:0];

    // States that are waiting for the next byte of a frame; only these run
    // the inter-byte timeout.
    always_comb begin
        collecting = 1'b0;
        unique case (state_q)
            S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_A, S_ALU_B, S_ALU_FUN,
            S_BR_ADDR, S_BR_CNT: collecting = 1'b1;
            default:             collecting = 1'b0;
        endcase
    end

    // A byte landing while we wait on the register file, ALU or FIFO is
    // dropped and flagged; the operation in flight carries on.
    assign stray_rx = RX_d_valid && !collecting && (state_q != S_IDLE);
    assign tmo_next = 32'(tmo_q) + 32'd1;
    assign tmo_hit  = (TIMEOUT != 0) && collecting && !RX_d_valid &&
                      (tmo_next == TMO_LIM);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        alu_res_d    = alu_res_q;
        tmo_d        = '0;
        alu_en_d     = 1'b0;
        alu_fun_d    = alu_fun_q;
        clk_en_d     = clk_en_q;
        address_d    = address_q;
        wren_d       = 1'b0;
        rden_d       = 1'b0;
        wrdata_d     = wrdata_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        clk_div_en_d = 1'b1;
        cmd_error_d  = 1'b0;

        if ((TIMEOUT != 0) && collecting && !RX_d_valid)
            tmo_d = TW'(tmo_next);

        unique case (state_q)
            S_IDLE: if (RX_d_valid) begin
                if      (RX_p_data == OP_WR)    state_d = S_WR_ADDR;
                else if (RX_p_data == OP_RD)    state_d = S_RD_ADDR;
                else if (RX_p_data == OP_ALU)   state_d = S_ALU_A;
                else if (RX_p_data == OP_ALU_N) state_d = S_ALU_FUN;
                else if (RX_p_data == OP_BURST) state_d = S_BR_ADDR;
                else                            cmd_error_d = 1'b1;
            end
            S_WR_ADDR: if (RX_d_valid) begin
                addr_d  = rx_addr;
                state_d = S_WR_DATA;
            end
            S_WR_DATA: if (RX_d_valid) begin
                wren_d    = 1'b1;
                address_d = addr_q;
                wrdata_d  = RX_p_data;
                state_d   = S_IDLE;
            end
            S_RD_ADDR: if (RX_d_valid) begin
                rden_d    = 1'b1;
                address_d = rx_addr;
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: if (RdData_valid) begin
                tx_data_d = Rd_data;
                state_d   = S_PUSH;
            end
            S_PUSH: if (!FIFO_full) begin
                tx_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_ALU_A: if (RX_d_valid) begin
                wren_d    = 1'b1;
                address_d = '0;
                wrdata_d  = RX_p_data;
                state_d   = S_ALU_B;
            end
            S_ALU_B: if (RX_d_valid) begin
                wren_d    = 1'b1;
                address_d = ADDR_WIDTH'(1);
                wrdata_d  = RX_p_data;
                state_d   = S_ALU_FUN;
            end
            S_ALU_FUN: if (RX_d_valid) begin
                alu_fun_d = RX_p_data[3:0];
                clk_en_d  = 1'b1;
                state_d   = S_ALU_START;
            end
            // One cycle of gated clock before the start pulse.
            S_ALU_START: begin
                alu_en_d = 1'b1;
                state_d  = S_ALU_WAIT;
            end
            S_ALU_WAIT: if (OUT_VALID) begin
                alu_res_d = ALU_OUT;
                clk_en_d  = 1'b0;
                state_d   = S_PUSH_LO;
            end
            // Data is driven every cycle so it is already stable when the
            // FIFO frees up and the strobe goes out.
            S_PUSH_LO: begin
                tx_data_d = alu_res_q[DATA_WIDTH-1:0];
                if (!FIFO_full) begin
                    tx_valid_d = 1'b1;
                    state_d    = S_PUSH_HI;
                end
            end
            S_PUSH_HI: begin
                tx_data_d = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                if (!FIFO_full) begin
                    tx_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_BR_ADDR: if (RX_d_valid) begin
                addr_d  = rx_addr;
                state_d = S_BR_CNT;
            end
            S_BR_CNT: if (RX_d_valid) begin
                cnt_d   = RX_p_data;
                state_d = (RX_p_data == '0) ? S_IDLE : S_BR_READ;
            end
            S_BR_READ: begin
                rden_d    = 1'b1;
                address_d = addr_q;
                state_d   = S_BR_WAIT;
            end
            S_BR_WAIT: if (RdData_valid) begin
                tx_data_d = Rd_data;
                state_d   = S_BR_PUSH;
            end
            // Address wraps naturally at 2^ADDR_WIDTH.
            S_BR_PUSH: if (!FIFO_full) begin
                tx_valid_d = 1'b1;
                addr_d     = addr_q + 1'b1;
                cnt_d      = cnt_q - 1'b1;
                state_d    = (cnt_q == DATA_WIDTH'(1)) ? S_IDLE : S_BR_READ;
            end
            default: state_d = S_IDLE;
        endcase

        // Abandon the partial frame; anything already written stays written.
        if (tmo_hit) begin
            state_d     = S_IDLE;
            cmd_error_d = 1'b1;
            tmo_d       = '0;
        end
        if (stray_rx)
            cmd_error_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            alu_res_q    <= '0;
            tmo_q        <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            clk_en_q     <= 1'b0;
            address_q    <= '0;
            wren_q       <= 1'b0;
            rden_q       <= 1'b0;
            wrdata_q     <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            clk_div_en_q <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            alu_res_q    <= alu_res_d;
            tmo_q        <= tmo_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            clk_en_q     <= clk_en_d;
            address_q    <= address_d;
            wren_q       <= wren_d;
            rden_q       <= rden_d;
            wrdata_q     <= wrdata_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            clk_div_en_q <= clk_div_en_d;
            cmd_error_q  <= cmd_error_d;
        end
    end

    assign ALU_EN     = alu_en_q;
    assign ALU_FUN    = alu_fun_q;
    assign CLK_EN     = clk_en_q;
    assign Address    = address_q;
    assign WrEN       = wren_q;
    assign RdEN       = rden_q;
    assign WrData     = wrdata_q;
    assign TX_p_data  = tx_data_q;
    assign TX_d_valid = tx_valid_q;
    assign clk_div_en = clk_div_en_q;
    assign cmd_error  = cmd_error_q;

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Bench for sys_ctrl_burst: frame-level model predicts the ordered list of
// register writes, reads, ALU starts, FIFO pushes and error pulses; a single
// monitor matches DUT strobes against those lists every cycle.
module tb_sys_ctrl_burst;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_p_data;
    logic        RX_d_valid;
    logic [7:0]  Rd_data;
    logic        RdData_valid;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        FIFO_full;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_EN;
    logic [3:0]  Address;
    logic        WrEN;
    logic        RdEN;
    logic [7:0]  WrData;
    logic [7:0]  TX_p_data;
    logic        TX_d_valid;
    logic        clk_div_en;
    logic        cmd_error;

    always #5 CLK = ~CLK;

    sys_ctrl_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .RX_p_data(RX_p_data), .RX_d_valid(RX_d_valid),
        .Rd_data(Rd_data), .RdData_valid(RdData_valid), .ALU_OUT(ALU_OUT),
        .OUT_VALID(OUT_VALID), .FIFO_full(FIFO_full), .ALU_EN(ALU_EN),
        .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .Address(Address), .WrEN(WrEN),
        .RdEN(RdEN), .WrData(WrData), .TX_p_data(TX_p_data),
        .TX_d_valid(TX_d_valid), .clk_div_en(clk_div_en), .cmd_error(cmd_error)
    );

    int checks = 0;
    int errors = 0;

    // Expected event streams (model side)
    logic [11:0] exp_wr[$];   // {addr, data}
    logic [3:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [3:0]  exp_alu[$];
    int          exp_err = 0;
    logic [7:0]  exp_regs[16];

    // Observations
    logic [7:0]  tx_log[$];
    int          tx_seen = 0;
    int          obs_err = 0;

    // Environment register file and poke requests
    logic [7:0]  rf[16];
    int          poke_rd = 0;
    int          poke_alu = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got strobe with %h expected none", name, act);
    endtask

    function automatic logic [15:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'd0:    alu_f = {8'h00, a} + {8'h00, b};
            4'd1:    alu_f = {8'h00, a} - {8'h00, b};
            4'd2:    alu_f = {8'h00, a} * {8'h00, b};
            default: alu_f = {a, b};
        endcase
    endfunction

    // ---------------- environment: register file ----------------
    initial begin : rf_env
        logic [7:0] d;
        int done;
        done = 0;
        Rd_data = 8'h00;
        RdData_valid = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        forever begin
            @(negedge CLK);
            if (WrEN) rf[Address] = WrData;
            if (RdEN) begin
                d = rf[Address];
                @(posedge CLK); #1;
                Rd_data = d; RdData_valid = 1'b1;
                @(posedge CLK); #1;
                RdData_valid = 1'b0;
            end else if (poke_rd != done) begin
                done = poke_rd;
                @(posedge CLK); #1;
                Rd_data = 8'hE7; RdData_valid = 1'b1;
                @(posedge CLK); #1;
                RdData_valid = 1'b0;
            end
        end
    end

    // ---------------- environment: ALU ----------------
    initial begin : alu_env
        logic [3:0] f;
        logic [7:0] a, b;
        int done;
        done = 0;
        OUT_VALID = 1'b0;
        ALU_OUT = 16'h0000;
        forever begin
            @(negedge CLK);
            if (ALU_EN) begin
                f = ALU_FUN; a = rf[0]; b = rf[1];
                repeat (2) @(posedge CLK);
                #1;
                ALU_OUT = alu_f(f, a, b); OUT_VALID = 1'b1;
                @(posedge CLK); #1;
                OUT_VALID = 1'b0;
            end else if (poke_alu != done) begin
                done = poke_alu;
                @(posedge CLK); #1;
                ALU_OUT = 16'hBEEF; OUT_VALID = 1'b1;
                @(posedge CLK); #1;
                OUT_VALID = 1'b0;
            end
        end
    end

    // ---------------- monitor / compare ----------------
    initial begin : monitor
        logic full_last, clk_en_last;
        full_last = 1'b0;
        clk_en_last = 1'b0;
        forever begin
            @(negedge CLK);
            if (WrEN) begin
                if (exp_wr.size() == 0) unexpected("wr_unexpected", {Address, WrData});
                else chk("wr", {Address, WrData}, exp_wr.pop_front());
            end
            if (RdEN) begin
                if (exp_rd.size() == 0) unexpected("rd_unexpected", Address);
                else chk("rd_addr", Address, exp_rd.pop_front());
            end
            if (ALU_EN) begin
                if (exp_alu.size() == 0) unexpected("alu_unexpected", ALU_FUN);
                else chk("alu_fun", ALU_FUN, exp_alu.pop_front());
                chk("alu_en_clk_en", {clk_en_last, CLK_EN}, 2'b11);
            end
            if (TX_d_valid) begin
                tx_log.push_back(TX_p_data);
                tx_seen++;
                chk("tx_not_when_full", full_last, 1'b0);
                if (exp_tx.size() == 0) unexpected("tx_unexpected", TX_p_data);
                else chk("tx_data", TX_p_data, exp_tx.pop_front());
            end
            if (cmd_error) obs_err++;
            full_last = FIFO_full;
            clk_en_last = CLK_EN;
        end
    end

    // ---------------- model + stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_p_data = b; RX_d_valid = 1'b1;
        @(posedge CLK); #1;
        RX_d_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        exp_wr.push_back({a[3:0], d});
        exp_regs[a[3:0]] = d;
        send_byte(8'hAA); send_byte(a); send_byte(d);
    endtask

    task automatic do_read(input logic [7:0] a);
        exp_rd.push_back(a[3:0]);
        exp_tx.push_back(exp_regs[a[3:0]]);
        send_byte(8'hBB); send_byte(a);
    endtask

    task automatic alu_expect(input logic [3:0] f);
        logic [15:0] r;
        r = alu_f(f, exp_regs[0], exp_regs[1]);
        exp_alu.push_back(f);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
    endtask

    task automatic do_alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        exp_wr.push_back({4'd0, a}); exp_regs[0] = a;
        exp_wr.push_back({4'd1, b}); exp_regs[1] = b;
        alu_expect(f[3:0]);
        send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(f);
    endtask

    task automatic do_alu_n(input logic [7:0] f);
        alu_expect(f[3:0]);
        send_byte(8'hDD); send_byte(f);
    endtask

    task automatic do_burst(input logic [7:0] a, input logic [7:0] n);
        logic [3:0] ad;
        ad = a[3:0];
        for (int i = 0; i < int'(n); i++) begin
            exp_rd.push_back(ad);
            exp_tx.push_back(exp_regs[ad]);
            ad = ad + 4'd1;
        end
        send_byte(8'hEE); send_byte(a); send_byte(n);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_tx.size() + exp_alu.size()) != 0 && n < 600) begin
            @(posedge CLK); n++;
        end
        chk({name, "_done"}, (n < 600), 1'b1);
        repeat (4) @(posedge CLK);
        #1;
    endtask

    function automatic logic [30:0] all_outs();
        all_outs = {ALU_EN, ALU_FUN, CLK_EN, Address, WrEN, RdEN, WrData,
                    TX_p_data, TX_d_valid, clk_div_en, cmd_error};
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        int t0, first;
        RST = 1'b0;
        RX_p_data = 8'h00; RX_d_valid = 1'b0; FIFO_full = 1'b0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;

        // reset state
        #2;
        chk("reset_outputs", all_outs(), 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        chk("clk_div_en_before_edge", clk_div_en, 1'b0);
        @(posedge CLK); #1;
        chk("clk_div_en_after_edge", clk_div_en, 1'b1);

        // write then read
        do_write(8'h05, 8'h3C);
        wait_idle("wr");
        do_read(8'h05);
        wait_idle("rd");
        chk("rd_push_literal", tx_log[tx_log.size()-1], 8'h3C);

        // ALU with operands: 0x0A + 0x03
        do_alu(8'h0A, 8'h03, 8'h00);
        wait_idle("alu");
        chk("alu_lo_literal", tx_log[tx_log.size()-2], 8'h0D);
        chk("alu_hi_literal", tx_log[tx_log.size()-1], 8'h00);
        chk("clk_en_low_after", CLK_EN, 1'b0);

        // ALU without operands: multiply of current reg0/reg1
        do_alu_n(8'h02);
        wait_idle("alu_n");
        chk("alu_n_lo_literal", tx_log[tx_log.size()-2], 8'h1E);

        // burst across the address wrap
        do_write(8'h0E, 8'h11);
        do_write(8'h0F, 8'h22);
        do_write(8'h00, 8'h33);
        wait_idle("br_setup");
        do_burst(8'h0E, 8'h03);
        wait_idle("burst");
        chk("burst_b0_literal", tx_log[tx_log.size()-3], 8'h11);
        chk("burst_b1_literal", tx_log[tx_log.size()-2], 8'h22);
        chk("burst_b2_literal", tx_log[tx_log.size()-1], 8'h33);

        // back-pressure, with a stray byte while waiting
        FIFO_full = 1'b1;
        t0 = tx_seen;
        do_read(8'h05);
        exp_err++;
        send_byte(8'h55);
        repeat (10) @(posedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("bp_data_stable", {TX_d_valid, TX_p_data}, {1'b0, 8'h3C});
        end
        chk("bp_no_push", tx_seen - t0, 0);
        FIFO_full = 1'b0;
        wait_idle("bp");
        chk("bp_one_push", tx_seen - t0, 1);
        chk("bp_stray_err", obs_err, exp_err);

        // unrequested read data / ALU result are ignored
        t0 = tx_seen;
        poke_rd++; poke_alu++;
        repeat (10) @(posedge CLK);
        #1;
        chk("spurious_no_push", tx_seen - t0, 0);
        chk("spurious_no_err", obs_err, exp_err);

        // inter-byte timeout
        exp_err++;
        send_byte(8'hAA);
        send_byte(8'h05);
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK); #1;
            if (cmd_error && first == 0) first = k;
        end
        chk("timeout_cycles", first, 16);
        chk("timeout_err_count", obs_err, exp_err);

        // unknown opcode, zero-length burst, then a normal frame
        exp_err++;
        send_byte(8'h7F);
        repeat (3) @(posedge CLK);
        #1;
        chk("bad_opcode_err", obs_err, exp_err);
        do_burst(8'h03, 8'h00);
        do_write(8'h03, 8'h5A);
        wait_idle("after_err");
        do_read(8'h03);
        wait_idle("after_err_rd");
        chk("after_err_literal", tx_log[tx_log.size()-1], 8'h5A);
        chk("cnt0_no_err", obs_err, exp_err);

        // reset in the middle of a burst
        t0 = tx_seen;
        do_burst(8'h00, 8'h08);
        first = 0;
        while (tx_seen - t0 < 2 && first < 300) begin
            @(posedge CLK); #1; first++;
        end
        chk("burst_two_pushes", tx_seen - t0, 2);
        RST = 1'b0;
        #1;
        chk("reset_mid_outputs", all_outs(), 0);
        exp_wr.delete(); exp_rd.delete(); exp_tx.delete(); exp_alu.delete();
        t0 = tx_seen;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        chk("clk_div_en_held_low", clk_div_en, 1'b0);
        @(posedge CLK); #1;
        chk("clk_div_en_restored", clk_div_en, 1'b1);
        repeat (30) @(posedge CLK);
        #1;
        chk("no_resume_after_reset", tx_seen - t0, 0);

        chk("final_err_count", obs_err, exp_err);
        chk("final_queues_empty", exp_wr.size() + exp_rd.size() + exp_tx.size() + exp_alu.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_burst.md
Name: sys_ctrl_burst

Overview:
Parametrised successor to the UART command controller. It parses byte frames arriving from the synchronised UART RX path and drives register-file writes and reads, ALU operations and TX-FIFO pushes. New relative to the previous controller: a burst-read command, a two-byte ALU result, an inter-byte timeout with frame abort, and a command-error flag. It sits in the reference-clock domain between DATA_SYNC, Register_file, ALU/CLK_gate and ASYNC_FIFO.

Parameters:
DATA_WIDTH, 8, byte/register width
ADDR_WIDTH, 4, register-file address width
TIMEOUT, 1024, inter-byte timeout in CLK cycles; 0 disables the timeout

Ports:
CLK  in  1  reference clock
RST  in  1  asynchronous active-low reset
RX_p_data  in  DATA_WIDTH  synchronised RX byte
RX_d_valid  in  1  one-cycle pulse; RX_p_data is valid in that cycle
Rd_data  in  DATA_WIDTH  register-file read data
RdData_valid  in  1  read data valid pulse
ALU_OUT  in  2*DATA_WIDTH  ALU result
OUT_VALID  in  1  ALU result valid
FIFO_full  in  1  TX FIFO full
ALU_EN  out  1  one-cycle ALU start pulse
ALU_FUN  out  4  ALU function code
CLK_EN  out  1  ALU clock-gate enable
Address  out  ADDR_WIDTH  register-file address
WrEN  out  1  register write strobe
RdEN  out  1  register read strobe
WrData  out  DATA_WIDTH  register write data
TX_p_data  out  DATA_WIDTH  FIFO write data
TX_d_valid  out  1  FIFO write strobe
clk_div_en  out  1  UART clock-divider enable
cmd_error  out  1  one-cycle error pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. clk_div_en goes to 1 on the first clock edge after reset release and stays 1.
- All outputs are registered. A strobe is asserted in the cycle after the RX_d_valid that completes the relevant field.
- Frame opcodes, received in IDLE:
  - 0xAA: write. Fields: addr, data. Action: WrEN=1 for one cycle with Address/WrData.
  - 0xBB: read. Field: addr. Action: RdEN for one cycle, then wait for RdData_valid, latch Rd_data, then push one byte.
  - 0xCC: ALU with operands. Fields: A, B, fun. A is written to addr 0 and B to addr 1 via WrEN, each written as it arrives. Then the ALU sequence runs.
  - 0xDD: ALU without operands. Field: fun. Then the ALU sequence runs.
  - 0xEE: burst read. Fields: addr, cnt. Action: cnt reads at addr, addr+1, … Each read is RdEN → RdData_valid → push, strictly in series.
- The upper bits of the addr byte beyond ADDR_WIDTH are ignored.
- Burst addressing: the address wraps modulo 2^ADDR_WIDTH. cnt=0 is a no-op and returns to IDLE without error.
- ALU sequence:
  - CLK_EN rises with ALU_FUN latched (fun[3:0]).
  - ALU_EN pulses the next cycle.
  - Wait for OUT_VALID and latch ALU_OUT; CLK_EN falls in the cycle after OUT_VALID.
  - Push the low byte, then the high byte.
- FIFO push: TX_d_valid is a one-cycle pulse, issued only in a cycle where FIFO_full=0. While FIFO_full=1 the FSM holds with TX_p_data stable and no pulse.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, PUSH, ALU_A, ALU_B, ALU_FUN, ALU_START, ALU_WAIT, PUSH_LO, PUSH_HI, BR_ADDR, BR_CNT, BR_READ, BR_WAIT, BR_PUSH.
- Unknown opcode in IDLE: cmd_error pulse, stay in IDLE.
- Timeout:
  - The counter runs only in byte-collecting states (WR_*, RD_ADDR, ALU_A/B/FUN, BR_ADDR/BR_CNT).
  - It clears on every RX_d_valid and on entry to IDLE.
  - When it reaches TIMEOUT: cmd_error pulse, frame discarded, go to IDLE. Fields already written (e.g. operand A) are not rolled back.
- RX_d_valid arriving in a non-collecting state (waits/pushes/burst): the byte is dropped, cmd_error pulses, and the current operation continues.
- RdData_valid or OUT_VALID arriving while not awaited: ignored.
- Reset mid-operation: immediate return to the reset values. A partially issued burst is not resumed.

Test Plan:
- Write then read: frame AA 05 3C, then BB 05 → one WrEN with Address=5, WrData=0x3C; then RdEN with Address=5; Rd_data=0x3C → single TX_d_valid with TX_p_data=0x3C.
- ALU with operands: frame CC 0A 03 00, ALU_OUT=0x000D → writes 0x0A@0 and 0x03@1; ALU_EN with ALU_FUN=0; pushes 0x0D then 0x00; CLK_EN is low again afterwards.
- Burst with wrap: regs 14,15,0 hold 0x11,0x22,0x33; frame EE 0E 03 → reads at addresses 14, 15, 0; pushes 0x11, 0x22, 0x33 in order; returns to IDLE.
- Back-pressure: FIFO_full=1 held for 20 cycles during the BB read push → no TX_d_valid while full, TX_p_data stable; exactly one pulse after FIFO_full falls.
- Timeout/error: with TIMEOUT=16, send AA 05 and then no byte → cmd_error pulse 16 cycles after the last byte, no WrEN; next, opcode 0x7F → cmd_error, FSM stays in IDLE; a subsequent valid frame executes normally.
- Reset during burst EE 00 08 after 2 pushes: assert RST → all outputs 0 immediately; no further pushes; clk_div_en returns to 1 one cycle after reset release.
